traffic_monitor: RTL and testbench
==================================

TRAFFIC_MONITOR -- requirements
Module: traffic_monitor

Interface
REQ-001 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-002 Parameter MIN_GREEN, default 4: minimum legal green dwell in cycles.
REQ-003 Parameter MIN_YELLOW, default 2: minimum legal yellow dwell in cycles.
REQ-004 Parameter MAX_PHASE, default 255: maximum dwell in any single light combination.
REQ-005 Parameter CNT_W, default 8: width of the dwell counter, which SHALL be able to hold MAX_PHASE.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_  input  1  synchronous reset, active-high despite the name.
REQ-008 ns_green, ns_yellow, ns_red  input  1 each  north-south lamp drives from the controller.
REQ-009 ew_green, ew_yellow, ew_red  input  1 each  east-west lamp drives from the controller.
REQ-010 clr_fault  input  1  clears a latched fault.
REQ-011 fault  output  1  sticky fault flag.
REQ-012 fault_code  output  3  first fault cause: 0 none, 1 bad encoding, 2 conflict, 3 bad transition, 4 short dwell, 5 timeout.
REQ-013 phase  output  3  monitor state: 0 SYNC, 1 NS_GO, 2 NS_WARN, 3 RED_A, 4 EW_GO, 5 EW_WARN, 6 RED_B, 7 FAULT.
REQ-014 dwell  output  CNT_W  cycles the current light combination has been held, saturating.
REQ-015 cycle_count  output  16  completed full NS+EW cycles, wrapping.

Function
REQ-016 Lamp inputs SHALL be sampled every rising edge; all outputs SHALL be registered and SHALL reflect the sample taken on that edge, giving 1-cycle latency.
REQ-017 Bad encoding: either direction not exactly one-hot across green/yellow/red SHALL produce code 1.
REQ-018 Conflict: both directions non-red at once SHALL produce code 2.
REQ-019 Legal combinations: NS_GO (ns G, ew R), NS_WARN (ns Y, ew R), RED (both R), EW_GO (ns R, ew G), EW_WARN (ns R, ew Y).
REQ-020 Legal transitions are NS_GO->NS_WARN, NS_WARN->RED_A or EW_GO, RED_A->EW_GO, EW_GO->EW_WARN, EW_WARN->RED_B or NS_GO, and RED_B->NS_GO.
REQ-021 Any other change of combination outside SYNC SHALL produce code 3.
REQ-022 In SYNC, samples of NS_WARN, EW_WARN or RED SHALL be ignored; NS_GO or EW_GO SHALL enter that state with dwell=1 and the short-dwell check disabled for that first phase only.
REQ-023 dwell SHALL load 1 on any combination change.
REQ-024 dwell SHALL otherwise increment by 1, saturating at 2^CNT_W-1.
REQ-025 Leaving a GO state with dwell < MIN_GREEN, or a WARN state with dwell < MIN_YELLOW, SHALL produce code 4; dwell is the value before the change.
REQ-026 dwell reaching MAX_PHASE+1 without a change SHALL produce code 5.
REQ-027 cycle_count SHALL increment on each entry to NS_GO from EW_WARN or RED_B, but not on entry from SYNC.
REQ-028 cycle_count SHALL wrap from 0xFFFF to 0.
REQ-029 On any fault: phase=7, fault=1, and fault_code is latched.
REQ-030 When faults coincide, the lowest code SHALL win.
REQ-031 While fault=1, further faults SHALL NOT change fault_code, and dwell SHALL keep counting.
REQ-032 clr_fault in FAULT SHALL return the block to SYNC with fault=0 and fault_code=0 on the next edge; cycle_count is retained.
REQ-033 If clr_fault coincides with a new fault sample, the new fault SHALL be latched.
REQ-034 clr_fault outside FAULT SHALL have no effect.

Reset
REQ-035 While rst_=1 on an edge, outputs SHALL become: phase=0 (SYNC), fault=0, fault_code=0, dwell=0, cycle_count=0.
REQ-036 Reset SHALL override clr_fault and all lamp inputs.
REQ-037 Reset asserted mid-phase or in FAULT SHALL restart from SYNC, with no fault raised for the partial phase.

Verification (MIN_GREEN=4, MIN_YELLOW=2, MAX_PHASE=20)
REQ-038 Legal cycle: reset, then NS_GO 5, NS_WARN 2, EW_GO 5, EW_WARN 2, NS_GO -> fault=0, phase sequence 1,2,4,5,1, cycle_count=1.
REQ-039 Conflict: ns_green=1 and ew_green=1 in one cycle -> next edge fault=1, fault_code=2, phase=7.
REQ-040 Bad transition: NS_GO 6 cycles, then EW_GO directly -> fault_code=3; a follow-on timeout SHALL NOT overwrite the code.
REQ-041 Short yellow: NS_WARN held 1 cycle, then RED -> fault_code=4; clr_fault pulse -> phase=0, fault=0, cycle_count unchanged.
REQ-042 Timeout: EW_GO held 21 cycles -> fault_code=5 on the 21st sample, with dwell=21.
REQ-043 Priority and reset: all six lamps=0 while also timing out -> fault_code=1; then rst_=1 -> all outputs 0 and phase=0.

Source files
------------

// File: rtl/traffic_monitor.sv
// traffic_monitor: watches the six lamp drives of a two-way traffic
// controller and latches the first illegal behaviour it sees.
//
// Ports:
//   clk          rising-edge clock
//   rst_         synchronous reset, active-high
//   ns_green/ns_yellow/ns_red   north-south lamp drives
//   ew_green/ew_yellow/ew_red   east-west lamp drives
//   clr_fault    clears a latched fault (only while in FAULT)
//   fault        sticky fault flag
//   fault_code   first cause: 0 none, 1 encoding, 2 conflict,
//                3 transition, 4 short dwell, 5 timeout
//   phase        monitor state (0 SYNC .. 7 FAULT)
//   dwell        cycles the current lamp combination has been held
//   cycle_count  completed NS+EW cycles, wrapping
//
// Every output is registered and reflects the lamp sample taken on the
// same rising edge.
module traffic_monitor #(
   parameter int MIN_GREEN  = 4,
   parameter int MIN_YELLOW = 2,
   parameter int MAX_PHASE  = 255,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             ns_green,
   input  logic             ns_yellow,
   input  logic             ns_red,
   input  logic             ew_green,
   input  logic             ew_yellow,
   input  logic             ew_red,
   input  logic             clr_fault,
   output logic             fault,
   output logic [2:0]       fault_code,
   output logic [2:0]       phase,
   output logic [CNT_W-1:0] dwell,
   output logic [15:0]      cycle_count
);

   typedef enum logic [2:0] {
      SYNC    = 3'd0,
      NS_GO   = 3'd1,
      NS_WARN = 3'd2,
      RED_A   = 3'd3,
      EW_GO   = 3'd4,
      EW_WARN = 3'd5,
      RED_B   = 3'd6,
      FAULT   = 3'd7
   } phase_t;

   typedef enum logic [2:0] {
      C_NS_GO, C_NS_WARN, C_RED, C_EW_GO, C_EW_WARN, C_BAD, C_CONFLICT
   } combo_t;

   localparam logic [CNT_W-1:0] MIN_G_C = CNT_W'(MIN_GREEN);
   localparam logic [CNT_W-1:0] MIN_Y_C = CNT_W'(MIN_YELLOW);
   localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_PHASE);

   phase_t           state_q, state_d;
   logic             fault_q, fault_d;
   logic [2:0]       code_q, code_d;
   logic [CNT_W-1:0] dwell_q, dwell_d;
   logic [15:0]      cc_q, cc_d;
   logic [5:0]       last_lamps_q;
   logic             last_valid_q;
   logic             first_q, first_d;   // first phase after SYNC: no short-dwell check

   logic [5:0] lamps;
   combo_t     combo;
   logic       changed, monitored;
   logic       trans_bad, short_dwell, timeout, count_up;
   phase_t     legal_nxt;
   logic [2:0] code_new;

   assign lamps = {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red};

   // A sample right after reset always counts as a change so dwell starts at 1.
   assign changed   = !last_valid_q || (lamps != last_lamps_q);
   assign monitored = (state_q != SYNC) && (state_q != FAULT);

   always_comb begin
      combo = C_BAD;
      if (!$onehot({ns_green, ns_yellow, ns_red}) || !$onehot({ew_green, ew_yellow, ew_red}))
         combo = C_BAD;
      else if (!ns_red && !ew_red)
         combo = C_CONFLICT;
      else if (ns_green)  combo = C_NS_GO;
      else if (ns_yellow) combo = C_NS_WARN;
      else if (ew_green)  combo = C_EW_GO;
      else if (ew_yellow) combo = C_EW_WARN;
      else                combo = C_RED;
   end

   // Transition check for the monitored states. Anything that is not "stay"
   // or a listed successor is a bad transition; short dwell is only judged
   // on legal exits from GO/WARN.
   always_comb begin
      legal_nxt   = state_q;
      trans_bad   = 1'b0;
      short_dwell = 1'b0;
      count_up    = 1'b0;
      case (state_q)
         NS_GO:
            if (combo == C_NS_WARN) begin
               legal_nxt   = NS_WARN;
               short_dwell = !first_q && (dwell_q < MIN_G_C);
            end else if (combo != C_NS_GO) trans_bad = 1'b1;
         NS_WARN:
            if (combo == C_RED || combo == C_EW_GO) begin
               legal_nxt   = (combo == C_RED) ? RED_A : EW_GO;
               short_dwell = !first_q && (dwell_q < MIN_Y_C);
            end else if (combo != C_NS_WARN) trans_bad = 1'b1;
         RED_A:
            if (combo == C_EW_GO) legal_nxt = EW_GO;
            else if (combo != C_RED) trans_bad = 1'b1;
         EW_GO:
            if (combo == C_EW_WARN) begin
               legal_nxt   = EW_WARN;
               short_dwell = !first_q && (dwell_q < MIN_G_C);
            end else if (combo != C_EW_GO) trans_bad = 1'b1;
         EW_WARN:
            if (combo == C_RED || combo == C_NS_GO) begin
               legal_nxt   = (combo == C_RED) ? RED_B : NS_GO;
               short_dwell = !first_q && (dwell_q < MIN_Y_C);
               count_up    = (combo == C_NS_GO);
            end else if (combo != C_EW_WARN) trans_bad = 1'b1;
         RED_B:
            if (combo == C_NS_GO) begin
               legal_nxt = NS_GO;
               count_up  = 1'b1;
            end else if (combo != C_RED) trans_bad = 1'b1;
         default: ;
      endcase
   end

   // Timeout fires on the sample that would take an unchanged dwell past
   // MAX_PHASE; using >= keeps it reachable when dwell saturates at MAX_PHASE.
   assign timeout = monitored && !changed && (dwell_q >= MAX_C);

   // Lowest code wins when causes coincide.
   always_comb begin
      code_new = 3'd0;
      if      (combo == C_BAD)             code_new = 3'd1;
      else if (combo == C_CONFLICT)        code_new = 3'd2;
      else if (monitored && trans_bad)     code_new = 3'd3;
      else if (monitored && short_dwell)   code_new = 3'd4;
      else if (timeout)                    code_new = 3'd5;
   end

   // NOTE: every output of this block is assigned a default first, so no
   // path through the case statements can leave a latch behind.
   always_comb begin
      state_d = state_q;
      fault_d = fault_q;
      code_d  = code_q;
      cc_d    = cc_q;
      first_d = first_q;
      dwell_d = changed ? CNT_W'(1) : ((dwell_q == '1) ? dwell_q : dwell_q + 1'b1);

      case (state_q)
         SYNC: begin
            if (code_new != 3'd0) begin
               state_d = FAULT;
               fault_d = 1'b1;
               code_d  = code_new;
            end else if (combo == C_NS_GO || combo == C_EW_GO) begin
               state_d = (combo == C_NS_GO) ? NS_GO : EW_GO;
               first_d = 1'b1;
               dwell_d = CNT_W'(1);
            end
         end
         FAULT: begin
            if (clr_fault) begin
               if (code_new != 3'd0) begin
                  code_d = code_new;     // clear and new fault together: keep the new one
               end else begin
                  state_d = SYNC;
                  fault_d = 1'b0;
                  code_d  = 3'd0;
               end
            end
         end
         default: begin
            if (code_new != 3'd0) begin
               state_d = FAULT;
               fault_d = 1'b1;
               code_d  = code_new;
            end else if (legal_nxt != state_q) begin
               state_d = legal_nxt;
               first_d = 1'b0;
               if (count_up) cc_d = cc_q + 16'd1;
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst_) begin
         state_q      <= SYNC;
         fault_q      <= 1'b0;
         code_q       <= 3'd0;
         dwell_q      <= '0;
         cc_q         <= 16'd0;
         last_lamps_q <= 6'd0;
         last_valid_q <= 1'b0;
         first_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         fault_q      <= fault_d;
         code_q       <= code_d;
         dwell_q      <= dwell_d;
         cc_q         <= cc_d;
         last_lamps_q <= lamps;
         last_valid_q <= 1'b1;
         first_q      <= first_d;
      end
   end

   assign phase       = state_q;
   assign fault       = fault_q;
   assign fault_code  = code_q;
   assign dwell       = dwell_q;
   assign cycle_count = cc_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// Self-checking bench for traffic_monitor (MIN_GREEN=4, MIN_YELLOW=2,
// MAX_PHASE=20, CNT_W=8). Lamp vectors are {nsG,nsY,nsR,ewG,ewY,ewR}.
module tb_traffic_monitor;

   localparam logic [5:0] NSG  = 6'b100_001;
   localparam logic [5:0] NSY  = 6'b010_001;
   localparam logic [5:0] RED  = 6'b001_001;
   localparam logic [5:0] EWG  = 6'b001_100;
   localparam logic [5:0] EWY  = 6'b001_010;
   localparam logic [5:0] CONF = 6'b100_100;
   localparam logic [5:0] ZERO = 6'b000_000;

   logic        clk = 1'b0;
   logic        rst_ = 1'b0;
   logic [5:0]  lamps = 6'd0;
   logic        clr_fault = 1'b0;
   logic        fault;
   logic [2:0]  fault_code;
   logic [2:0]  phase;
   logic [7:0]  dwell;
   logic [15:0] cycle_count;

   int n_tests = 0;
   int n_fail  = 0;

   traffic_monitor #(
      .MIN_GREEN(4), .MIN_YELLOW(2), .MAX_PHASE(20), .CNT_W(8)
   ) dut (
      .clk(clk), .rst_(rst_),
      .ns_green(lamps[5]), .ns_yellow(lamps[4]), .ns_red(lamps[3]),
      .ew_green(lamps[2]), .ew_yellow(lamps[1]), .ew_red(lamps[0]),
      .clr_fault(clr_fault),
      .fault(fault), .fault_code(fault_code), .phase(phase),
      .dwell(dwell), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [5:0] lamps;
      logic       clr;
      logic       rst;
      int         reps;
      logic [2:0] phase;
      logic       fault;
      logic [2:0] code;
      logic [7:0] dwell;
      logic [15:0] cc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(string n, logic [5:0] l, logic c, logic r, int reps,
                               logic [2:0] ph, logic f, logic [2:0] code,
                               logic [7:0] d, logic [15:0] cc);
      vec_t v;
      v.name = n; v.lamps = l; v.clr = c; v.rst = r; v.reps = reps;
      v.phase = ph; v.fault = f; v.code = code; v.dwell = d; v.cc = cc;
      return v;
   endfunction

   // got/exp packed as {phase, fault, code, dwell, cycle_count}
   task automatic check(input string name, input logic [30:0] got, input logic [30:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got phase=%0d fault=%0d code=%0d dwell=%0d cc=%0d, want phase=%0d fault=%0d code=%0d dwell=%0d cc=%0d",
                  name, got[30:28], got[27], got[26:24], got[23:16], got[15:0],
                  exp[30:28], exp[27], exp[26:24], exp[23:16], exp[15:0]);
      end
   endtask

   function automatic logic [30:0] outs();
      return {phase, fault, fault_code, dwell, cycle_count};
   endfunction

   task automatic step(input logic [5:0] l, input logic c, input logic r);
      lamps = l; clr_fault = c; rst_ = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // name, lamps, clr, rst, reps, phase, fault, code, dwell, cc
      tbl.push_back(mk("reset",          NSG,  0, 1,  2, 0, 0, 0,  0, 0));
      tbl.push_back(mk("sync_ignore_red",RED,  0, 0,  3, 0, 0, 0,  3, 0));
      tbl.push_back(mk("ns_go",          NSG,  0, 0,  5, 1, 0, 0,  5, 0));
      tbl.push_back(mk("ns_warn",        NSY,  0, 0,  2, 2, 0, 0,  2, 0));
      tbl.push_back(mk("ew_go",          EWG,  0, 0,  5, 4, 0, 0,  5, 0));
      tbl.push_back(mk("ew_warn",        EWY,  0, 0,  2, 5, 0, 0,  2, 0));
      tbl.push_back(mk("cycle_done",     NSG,  0, 0,  1, 1, 0, 0,  1, 1));
      tbl.push_back(mk("clr_no_effect",  NSG,  1, 0,  1, 1, 0, 0,  2, 1));
      tbl.push_back(mk("ns_go_more",     NSG,  0, 0,  3, 1, 0, 0,  5, 1));
      tbl.push_back(mk("short_yel_in",   NSY,  0, 0,  1, 2, 0, 0,  1, 1));
      tbl.push_back(mk("short_yellow",   RED,  0, 0,  1, 7, 1, 4,  1, 1));
      tbl.push_back(mk("fault_dwell",    RED,  0, 0,  2, 7, 1, 4,  3, 1));
      tbl.push_back(mk("clear",          RED,  1, 0,  1, 0, 0, 0,  4, 1));
      tbl.push_back(mk("first_go",       NSG,  0, 0,  1, 1, 0, 0,  1, 1));
      tbl.push_back(mk("first_exempt",   NSY,  0, 0,  1, 2, 0, 0,  1, 1));
      tbl.push_back(mk("second_short",   RED,  0, 0,  1, 7, 1, 4,  1, 1));
      tbl.push_back(mk("clr_vs_conflict",CONF, 1, 0,  1, 7, 1, 2,  1, 1));
      tbl.push_back(mk("clear2",         RED,  1, 0,  1, 0, 0, 0,  1, 1));
      tbl.push_back(mk("ew_go6",         EWG,  0, 0,  6, 4, 0, 0,  6, 1));
      tbl.push_back(mk("bad_transition", NSG,  0, 0,  1, 7, 1, 3,  1, 1));
      tbl.push_back(mk("no_overwrite",   NSG,  0, 0, 25, 7, 1, 3, 26, 1));
      tbl.push_back(mk("reset_fault",    NSG,  0, 1,  1, 0, 0, 0,  0, 0));
      tbl.push_back(mk("sync_conflict",  CONF, 0, 0,  1, 7, 1, 2,  1, 0));
      tbl.push_back(mk("reset2",         CONF, 1, 1,  1, 0, 0, 0,  0, 0));
      tbl.push_back(mk("ew_go20",        EWG,  0, 0, 20, 4, 0, 0, 20, 0));
      tbl.push_back(mk("timeout",        EWG,  0, 0,  1, 7, 1, 5, 21, 0));
      tbl.push_back(mk("clear3",         EWG,  1, 0,  1, 0, 0, 0, 22, 0));
      tbl.push_back(mk("ew_go20b",       EWG,  0, 0, 20, 4, 0, 0, 20, 0));
      tbl.push_back(mk("enc_beats_to",   ZERO, 0, 0,  1, 7, 1, 1,  1, 0));
      tbl.push_back(mk("reset3",         ZERO, 0, 1,  1, 0, 0, 0,  0, 0));
      tbl.push_back(mk("b_ns_go",        NSG,  0, 0,  4, 1, 0, 0,  4, 0));
      tbl.push_back(mk("b_ns_warn",      NSY,  0, 0,  2, 2, 0, 0,  2, 0));
      tbl.push_back(mk("red_a",          RED,  0, 0,  1, 3, 0, 0,  1, 0));
      tbl.push_back(mk("b_ew_go",        EWG,  0, 0,  4, 4, 0, 0,  4, 0));
      tbl.push_back(mk("b_ew_warn",      EWY,  0, 0,  2, 5, 0, 0,  2, 0));
      tbl.push_back(mk("red_b",          RED,  0, 0,  1, 6, 0, 0,  1, 0));
      tbl.push_back(mk("red_b_to_ns",    NSG,  0, 0,  1, 1, 0, 0,  1, 1));
      tbl.push_back(mk("go_to_ewy",      EWY,  0, 0,  1, 7, 1, 3,  1, 1));

      foreach (tbl[i]) begin
         for (int r = 0; r < tbl[i].reps; r++)
            step(tbl[i].lamps, tbl[i].clr, tbl[i].rst);
         check(tbl[i].name, outs(),
               {tbl[i].phase, tbl[i].fault, tbl[i].code, tbl[i].dwell, tbl[i].cc});
      end

      // Hand sequence: dwell tracked every cycle up to the timeout sample.
      step(ZERO, 0, 1);
      for (int i = 1; i <= 21; i++) begin
         step(EWG, 0, 0);
         if (i < 21)
            check($sformatf("dwell_%0d", i), outs(), {3'd4, 1'b0, 3'd0, 8'(i), 16'd0});
         else
            check("timeout_21", outs(), {3'd7, 1'b1, 3'd5, 8'd21, 16'd0});
      end

      // Hand sequence: outputs only move on the clock edge.
      step(ZERO, 0, 1);
      step(NSG, 0, 0);
      lamps = CONF;
      #3;
      check("latency_hold", outs(), {3'd1, 1'b0, 3'd0, 8'd1, 16'd0});
      @(posedge clk);
      #1;
      check("latency_edge", outs(), {3'd7, 1'b1, 3'd2, 8'd1, 16'd0});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
